// File: rtl/if_fetch_stage.sv
// Fetch stage and IF/ID pipeline register.
// Issues one instruction-memory request at a time, hands returned instructions to decode, parks
// one returned instruction in a skid buffer while the pipeline is stalled, and discards the stale
// response to a request that was in flight when a branch flush arrived.
//
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   PC_EN_IN            hazard unit: 0 holds the PC
//   IF_ID_EN_IN         hazard unit: 0 holds IF/ID
//   FLUSH_IN            taken branch/jump from EX; BRANCH_TARGET_IN is the redirect address
//   IMEM_REQ_OUT        fetch request, held until IMEM_VALID_IN
//   IMEM_ADDR_OUT       fetch address (the PC register)
//   IMEM_RDATA_IN       returned instruction, qualified by IMEM_VALID_IN
//   INSTR_IF_ID_OUT     IF/ID instruction
//   PC_IF_ID_OUT        IF/ID PC
//   VALID_IF_ID_OUT     IF/ID holds a real instruction
//   FETCH_STALL_OUT     fetch is waiting on memory
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00400000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_EN_IN,
  input  logic        IF_ID_EN_IN,
  input  logic        FLUSH_IN,
  input  logic [31:0] BRANCH_TARGET_IN,
  output logic        IMEM_REQ_OUT,
  output logic [31:0] IMEM_ADDR_OUT,
  input  logic [31:0] IMEM_RDATA_IN,
  input  logic        IMEM_VALID_IN,
  output logic [31:0] INSTR_IF_ID_OUT,
  output logic [31:0] PC_IF_ID_OUT,
  output logic        VALID_IF_ID_OUT,
  output logic        FETCH_STALL_OUT
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic        valid_q, valid_d;
  logic        adv;

  assign adv = PC_EN_IN & IF_ID_EN_IN;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    skid_d  = skid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;

    if (FLUSH_IN) begin
      // Redirect wins over stalls; any skid content is dropped by leaving StHold.
      pc_d    = BRANCH_TARGET_IN;
      instr_d = NOP_INSTR;
      ifpc_d  = BRANCH_TARGET_IN;
      valid_d = 1'b0;
      unique case (state_q)
        StFetch: state_d = IMEM_VALID_IN ? StFetch : StDrain;
        StHold:  state_d = StFetch;
        // A response landing in the same cycle is the stale one, so no request is left open.
        StDrain: state_d = IMEM_VALID_IN ? StFetch : StDrain;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (IMEM_VALID_IN && adv) begin
            instr_d = IMEM_RDATA_IN;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end else if (IMEM_VALID_IN) begin
            skid_d  = IMEM_RDATA_IN;
            state_d = StHold;
            if (IF_ID_EN_IN) begin
              instr_d = NOP_INSTR;
              ifpc_d  = pc_q;
              valid_d = 1'b0;
            end
          end else if (IF_ID_EN_IN) begin
            instr_d = NOP_INSTR;
            ifpc_d  = pc_q;
            valid_d = 1'b0;
          end
        end
        StHold: begin
          if (adv) begin
            instr_d = skid_q;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = StFetch;
          end
        end
        StDrain: begin
          if (IMEM_VALID_IN) begin
            state_d = StFetch;
          end
          if (IF_ID_EN_IN) begin
            instr_d = NOP_INSTR;
            ifpc_d  = pc_q;
            valid_d = 1'b0;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      skid_q  <= NOP_INSTR;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  // Request stays low through the reset cycle whatever state the register holds.
  assign IMEM_REQ_OUT    = (state_q == StFetch) & ~RST;
  assign IMEM_ADDR_OUT   = pc_q;
  assign INSTR_IF_ID_OUT = instr_q;
  assign PC_IF_ID_OUT    = ifpc_q;
  assign VALID_IF_ID_OUT = valid_q;
  assign FETCH_STALL_OUT = ((state_q == StFetch) & ~IMEM_VALID_IN) | (state_q == StDrain);

endmodule
